alu_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one ALU/multiplier execution unit between two requesters (r0, r1). It accepts an operation with a valid/ready handshake and launches it on the execution unit with a one-cycle start pulse. It waits for the unit's done strobe and returns the result to the originating requester with a valid/ready handshake. It sits between the core's issue logic and the shared ALU, so the multi-cycle Booth multiply can serve both requesters without conflict.

---
 rtl/alu_req_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_req_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that sequences one shared ALU/multiplier between two requesters.
// Optional exe_done watchdog is built when ALU_ARB_TIMEOUT_EN is defined.
module alu_req_arbiter #(
  parameter int N       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         r0_valid,
  output logic         r0_ready,
  input  logic [2:0]   r0_op,
  input  logic [N-1:0] r0_a,
  input  logic [N-1:0] r0_b,
  input  logic         r1_valid,
  output logic         r1_ready,
  input  logic [2:0]   r1_op,
  input  logic [N-1:0] r1_a,
  input  logic [N-1:0] r1_b,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp_data,
  output logic         rsp_err,
  output logic         exe_start,
  output logic [2:0]   exe_op,
  output logic [N-1:0] exe_a,
  output logic [N-1:0] exe_b,
  input  logic         exe_done,
  input  logic [N-1:0] exe_result
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   grant_q;
  logic   grant;
  logic   any_valid;
  logic   accept;
  logic   rsp_hs;
  logic   timeout_hit;

  // Grant favours whichever requester was not served last when both compete.
  always_comb begin
    any_valid  = r0_valid | r1_valid;
    grant      = (r0_valid && r1_valid) ? ~last_grant : r1_valid;
    r0_ready   = rst_n && (state == IDLE) && any_valid && !grant;
    r1_ready   = rst_n && (state == IDLE) && any_valid && grant;
    accept     = (r0_valid && r0_ready) || (r1_valid && r1_ready);
    exe_start  = (state == ISSUE);
    rsp0_valid = (state == RESP) && !grant_q;
    rsp1_valid = (state == RESP) && grant_q;
    rsp_hs     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
    state_nxt  = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (exe_done || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      exe_op     <= '0;
      exe_a      <= '0;
      exe_b      <= '0;
      rsp_data   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        grant_q <= grant;
        exe_op  <= grant ? r1_op : r0_op;
        exe_a   <= grant ? r1_a  : r0_a;
        exe_b   <= grant ? r1_b  : r0_b;
      end
      if (timeout_hit) begin
        rsp_data <= '0;
      end else if ((state == WAIT) && exe_done) begin
        rsp_data <= exe_result;
      end
      if (rsp_hs) begin
        last_grant <= grant_q;
      end
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] wait_cnt;
  logic            err_q;

  // A done arriving on the final WAIT cycle still wins over the timeout.
  assign timeout_hit = (state == WAIT) && !exe_done && (wait_cnt == CntW'(TIMEOUT - 1));
  assign rsp_err     = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end else if (rsp_hs) begin
        err_q <= 1'b0;
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT < 1);
  assign timeout_hit    = 1'b0;
  assign rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: directed scenarios plus randomized traffic
// checked against a round-robin/latency reference model.
module tb_alu_req_arbiter;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         r0_valid, r0_ready, r1_valid, r1_ready;
  logic [2:0]   r0_op, r1_op, exe_op;
  logic [N-1:0] r0_a, r0_b, r1_a, r1_b;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [N-1:0] rsp_data, exe_a, exe_b, exe_result;
  logic         rsp_err, exe_start, exe_done;

  alu_req_arbiter #(.N(N), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .exe_start(exe_start), .exe_op(exe_op), .exe_a(exe_a), .exe_b(exe_b),
    .exe_done(exe_done), .exe_result(exe_result)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int model_last;
  logic [N-1:0] exp_last;

  bit           in_v [2];
  logic [2:0]   cmd_op [2];
  logic [N-1:0] cmd_a [2];
  logic [N-1:0] cmd_b [2];
  int           done_dly, bp_cycles;
  bit           stray_issue;

  int           obs_grant, obs_hs, obs_start, obs_rsp, obs_starts, obs_valid_cycles;
  logic [N-1:0] obs_data, obs_a, obs_b;
  logic [2:0]   obs_op;
  logic         obs_err, obs_err_after;
  bit           obs_wrong, obs_busy, obs_unstable, obs_timeout;

  // Behavioural execution unit: the arbiter only forwards, so any fixed op map works.
  function automatic logic [N-1:0] ref_alu(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] r;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a * b;
      3'b011:  r = a & b;
      3'b100:  r = a ^ b;
      3'b101:  r = a << b[4:0];
      3'b110:  r = a >> b[4:0];
      default: r = a | b;
    endcase
    return r;
  endfunction

  function automatic int exp_grant();
    if (in_v[0] && in_v[1]) return 1 - model_last;
    return in_v[1] ? 1 : 0;
  endfunction

  task automatic drive_cmds();
    r0_valid = in_v[0]; r0_op = cmd_op[0]; r0_a = cmd_a[0]; r0_b = cmd_b[0];
    r1_valid = in_v[1]; r1_op = cmd_op[1]; r1_a = cmd_a[1]; r1_b = cmd_b[1];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_v = '{0, 0};
    drive_cmds();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0; exe_done = 1'b0; exe_result = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_last = 1;
  endtask

  // Runs one transaction with a behavioural exe unit and records what the DUT did.
  task automatic run_txn();
    bit hs_done = 0, rsp_done = 0, stray_now, real_done;
    obs_grant = -1; obs_hs = -1; obs_start = -1; obs_rsp = -1; obs_starts = 0;
    obs_valid_cycles = 0; obs_wrong = 0; obs_busy = 0; obs_unstable = 0; obs_timeout = 0;
    obs_err = 1'b0; obs_data = '0;
    drive_cmds();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    for (int k = 0; k < 400 && !rsp_done; k++) begin
      stray_now = stray_issue && hs_done && (k == obs_hs + 1);
      real_done = (obs_start >= 0) && (done_dly > 0) && (k == obs_start + done_dly);
      exe_done = stray_now | real_done;
      exe_result = real_done ? ref_alu(obs_op, obs_a, obs_b) : N'($urandom);
      if (hs_done) begin
        if (obs_grant == 0) begin
          r0_valid = 1'b0; rsp0_ready = (obs_valid_cycles >= bp_cycles); rsp1_ready = 1'b1;
        end else begin
          r1_valid = 1'b0; rsp1_ready = (obs_valid_cycles >= bp_cycles); rsp0_ready = 1'b1;
        end
      end
      #1;
      if (!hs_done) begin
        if (rsp0_valid || rsp1_valid || exe_start) obs_wrong = 1;
        if (r0_valid && r0_ready) obs_grant = 0;
        else if (r1_valid && r1_ready) obs_grant = 1;
        if (obs_grant >= 0) begin
          hs_done = 1; obs_hs = k;
        end
      end else begin
        if (r0_ready || r1_ready) obs_busy = 1;
        if (exe_start) begin
          obs_starts++;
          if (obs_start < 0) begin
            obs_start = k; obs_op = exe_op; obs_a = exe_a; obs_b = exe_b;
          end
        end else if (obs_start >= 0 && (exe_op !== obs_op || exe_a !== obs_a || exe_b !== obs_b)) begin
          obs_unstable = 1;
        end
        if ((obs_grant == 0) ? rsp1_valid : rsp0_valid) obs_wrong = 1;
        if ((obs_grant == 0) ? rsp0_valid : rsp1_valid) begin
          if (obs_rsp < 0) begin
            obs_rsp = k; obs_data = rsp_data; obs_err = rsp_err;
          end else if (rsp_data !== obs_data || rsp_err !== obs_err) begin
            obs_unstable = 1;
          end
          obs_valid_cycles++;
          if ((obs_grant == 0) ? rsp0_ready : rsp1_ready) rsp_done = 1;
        end else if (obs_rsp >= 0) begin
          obs_unstable = 1;
        end
      end
      @(posedge clk); #1;
    end
    if (!rsp_done) obs_timeout = 1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0; exe_done = 1'b0;
    obs_err_after = rsp_err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_v = '{1, 1};
    drive_cmds();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0; exe_done = 1'b0; exe_result = '0;
    stray_issue = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if ({r0_ready, r1_ready} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready: got %b want 00", {r0_ready, r1_ready}); end
    checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b want 00", {rsp0_valid, rsp1_valid}); end
    checks++; if (exe_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_exe_start: got %b want 0", exe_start); end
    checks++; if (rsp_data !== '0 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp: got data %0h err %b want 0 0", rsp_data, rsp_err); end
    checks++; if (exe_op !== 3'b000 || exe_a !== '0 || exe_b !== '0) begin errors++; $display("[TB] FAIL reset_exe_regs: got %0h %0h %0h want 0 0 0", exe_op, exe_a, exe_b); end
    rst_n = 1'b1;
    model_last = 1;
    #1;
    checks++; if ({r0_ready, r1_ready} !== 2'b10) begin errors++; $display("[TB] FAIL reset_first_priority: got %b want 10", {r0_ready, r1_ready}); end
    in_v = '{0, 0};
    drive_cmds();
    @(posedge clk); #1;
  endtask

  task automatic test_single_add();
    in_v = '{1, 0};
    cmd_op[0] = 3'b000; cmd_a[0] = 5; cmd_b[0] = 7;
    done_dly = 1; bp_cycles = 0;
    run_txn();
    checks++; if (obs_timeout || obs_grant != 0) begin errors++; $display("[TB] FAIL add_grant: got %0d (timeout %0d) want 0", obs_grant, obs_timeout); end
    checks++; if (obs_start != obs_hs + 1) begin errors++; $display("[TB] FAIL add_start_latency: got %0d want %0d", obs_start, obs_hs + 1); end
    checks++; if (obs_rsp != obs_hs + 3) begin errors++; $display("[TB] FAIL add_rsp_latency: got %0d want %0d", obs_rsp, obs_hs + 3); end
    checks++; if (obs_data !== 32'd12) begin errors++; $display("[TB] FAIL add_data: got %0d want 12", obs_data); end
    checks++; if (obs_a !== 32'd5 || obs_b !== 32'd7 || obs_op !== 3'b000) begin errors++; $display("[TB] FAIL add_exe_operands: got %0h %0d %0d want 0 5 7", obs_op, obs_a, obs_b); end
    checks++; if (obs_wrong || obs_starts != 1 || obs_err !== 1'b0) begin errors++; $display("[TB] FAIL add_clean: got wrong %0d starts %0d err %b want 0 1 0", obs_wrong, obs_starts, obs_err); end
    model_last = 0;
  endtask

  task automatic test_contention();
    int exp_g [3] = '{0, 1, 0};
    logic [N-1:0] exp_d [3] = '{32'd3, 32'hFF, 32'd3};
    do_reset();
    cmd_op[0] = 3'b000; cmd_a[0] = 1;     cmd_b[0] = 2;
    cmd_op[1] = 3'b111; cmd_a[1] = 'hF0;  cmd_b[1] = 'h0F;
    done_dly = 1; bp_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      in_v = '{1, 1};
      run_txn();
      checks++; if (obs_timeout || obs_grant != exp_g[i] || obs_grant != exp_grant()) begin errors++; $display("[TB] FAIL contention_grant%0d: got %0d want %0d", i, obs_grant, exp_g[i]); end
      checks++; if (obs_data !== exp_d[i]) begin errors++; $display("[TB] FAIL contention_data%0d: got %0h want %0h", i, obs_data, exp_d[i]); end
      checks++; if (obs_wrong || obs_busy) begin errors++; $display("[TB] FAIL contention_exclusive%0d: got wrong %0d busy %0d want 0 0", i, obs_wrong, obs_busy); end
      model_last = exp_g[i];
    end
  endtask

  task automatic test_mul_backpressure();
    in_v = '{1, 1};
    cmd_op[1] = 3'b010; cmd_a[1] = 3; cmd_b[1] = 4;
    done_dly = 40; bp_cycles = 5;
    run_txn();
    checks++; if (obs_timeout || obs_grant != 1) begin errors++; $display("[TB] FAIL mul_grant: got %0d (timeout %0d) want 1", obs_grant, obs_timeout); end
    checks++; if (obs_data !== 32'd12) begin errors++; $display("[TB] FAIL mul_data: got %0d want 12", obs_data); end
    checks++; if (obs_rsp != obs_hs + 42) begin errors++; $display("[TB] FAIL mul_latency: got %0d want %0d", obs_rsp, obs_hs + 42); end
    checks++; if (obs_valid_cycles != 6 || obs_unstable) begin errors++; $display("[TB] FAIL mul_hold: got %0d cycles unstable %0d want 6 0", obs_valid_cycles, obs_unstable); end
    checks++; if (obs_busy || obs_wrong) begin errors++; $display("[TB] FAIL mul_r0_blocked: got busy %0d wrong %0d want 0 0", obs_busy, obs_wrong); end
    model_last = 1;
  endtask

  task automatic test_reset_mid_wait();
    bit got = 0, seen = 0;
    in_v = '{1, 0};
    cmd_op[0] = 3'b010; cmd_a[0] = 6; cmd_b[0] = 7;
    drive_cmds();
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      if (r0_ready) got = 1;
      @(posedge clk); #1;
    end
    checks++; if (!got) begin errors++; $display("[TB] FAIL midreset_accept: got no r0_ready want r0_ready"); end
    r0_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exe_done = 1'b1; exe_result = 32'h1234;
    @(posedge clk); #1;
    exe_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (rsp0_valid || rsp1_valid || exe_start) seen = 1;
      @(posedge clk); #1;
    end
    checks++; if (seen) begin errors++; $display("[TB] FAIL midreset_no_rsp: got activity want none"); end
    checks++; if (rsp_data !== '0) begin errors++; $display("[TB] FAIL midreset_data: got %0h want 0", rsp_data); end
    model_last = 1;
    in_v = '{1, 0};
    cmd_op[0] = 3'b000; cmd_a[0] = 9; cmd_b[0] = 10;
    done_dly = 2; bp_cycles = 0;
    run_txn();
    checks++; if (obs_timeout || obs_grant != 0 || obs_data !== 32'd19) begin errors++; $display("[TB] FAIL midreset_next: got grant %0d data %0d want 0 19", obs_grant, obs_data); end
    model_last = 0;
    exp_last = 32'd19;
  endtask

  task automatic test_stray_done();
    bit seen = 0;
    in_v = '{0, 0};
    drive_cmds();
    exe_done = 1'b1; exe_result = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    exe_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (rsp0_valid || rsp1_valid || exe_start || r0_ready || r1_ready) seen = 1;
      @(posedge clk); #1;
    end
    checks++; if (seen) begin errors++; $display("[TB] FAIL stray_idle_activity: got activity want none"); end
    checks++; if (rsp_data !== exp_last) begin errors++; $display("[TB] FAIL stray_idle_data: got %0h want %0h", rsp_data, exp_last); end
    in_v = '{0, 1};
    cmd_op[1] = 3'b001; cmd_a[1] = 100; cmd_b[1] = 58;
    done_dly = 3; bp_cycles = 0; stray_issue = 1;
    run_txn();
    stray_issue = 0;
    checks++; if (obs_timeout || obs_grant != 1 || obs_data !== 32'd42) begin errors++; $display("[TB] FAIL stray_issue_data: got grant %0d data %0d want 1 42", obs_grant, obs_data); end
    checks++; if (obs_rsp != obs_hs + 5 || obs_starts != 1) begin errors++; $display("[TB] FAIL stray_issue_latency: got rsp %0d starts %0d want %0d 1", obs_rsp, obs_starts, obs_hs + 5); end
    model_last = 1;
  endtask

  task automatic test_random();
    int eg;
    logic [N-1:0] ed;
    in_v = '{0, 0};
    for (int i = 0; i < 30; i++) begin
      for (int s = 0; s < 2; s++) begin
        if (!in_v[s]) begin
          in_v[s] = 1'($urandom_range(0, 1));
          cmd_op[s] = 3'($urandom_range(0, 7));
          cmd_a[s] = N'($urandom); cmd_b[s] = N'($urandom);
        end
      end
      if (!in_v[0] && !in_v[1]) in_v[$urandom_range(0, 1)] = 1;
      eg = exp_grant();
      ed = ref_alu(cmd_op[eg], cmd_a[eg], cmd_b[eg]);
      done_dly = $urandom_range(1, 6); bp_cycles = $urandom_range(0, 3);
      stray_issue = 1'($urandom_range(0, 1));
      run_txn();
      checks++; if (obs_timeout || obs_grant != eg) begin errors++; $display("[TB] FAIL rand%0d_grant: got %0d want %0d", i, obs_grant, eg); end
      checks++; if (obs_data !== ed || obs_err !== 1'b0) begin errors++; $display("[TB] FAIL rand%0d_data: got %0h err %b want %0h 0", i, obs_data, obs_err, ed); end
      checks++; if (obs_rsp != obs_hs + done_dly + 2 || obs_valid_cycles != bp_cycles + 1) begin errors++; $display("[TB] FAIL rand%0d_timing: got rsp %0d cycles %0d want %0d %0d", i, obs_rsp, obs_valid_cycles, obs_hs + done_dly + 2, bp_cycles + 1); end
      checks++; if (obs_wrong || obs_busy || obs_unstable || obs_starts != 1) begin errors++; $display("[TB] FAIL rand%0d_protocol: got wrong %0d busy %0d unstable %0d starts %0d", i, obs_wrong, obs_busy, obs_unstable, obs_starts); end
      model_last = eg;
      in_v[eg] = 0;
    end
    stray_issue = 0;
    in_v = '{0, 0};
    drive_cmds();
  endtask

`ifdef ALU_ARB_TIMEOUT_EN
  task automatic test_timeout();
    in_v = '{1, 0};
    cmd_op[0] = 3'b000; cmd_a[0] = 1; cmd_b[0] = 1;
    done_dly = -1; bp_cycles = 1;
    run_txn();
    checks++; if (obs_timeout || obs_grant != 0) begin errors++; $display("[TB] FAIL timeout_grant: got %0d (timeout %0d) want 0", obs_grant, obs_timeout); end
    checks++; if (obs_rsp != obs_hs + 10) begin errors++; $display("[TB] FAIL timeout_latency: got %0d want %0d", obs_rsp, obs_hs + 10); end
    checks++; if (obs_err !== 1'b1 || obs_data !== '0) begin errors++; $display("[TB] FAIL timeout_flag: got err %b data %0h want 1 0", obs_err, obs_data); end
    checks++; if (obs_err_after !== 1'b0) begin errors++; $display("[TB] FAIL timeout_err_clear: got %b want 0", obs_err_after); end
    model_last = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_add();
    test_contention();
    test_mul_backpressure();
    test_reset_mid_wait();
    test_stray_done();
    test_random();
`ifdef ALU_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
